// File: rtl/char_pkg.sv
// char_pkg: shared state encoding, control codes, grid size and RAM address layout
package char_pkg;
  localparam int COLS = 64;
  localparam int ROWS = 30;
  localparam logic [6:0] BLANK = 7'h20;
  localparam logic [6:0] CR = 7'h0D;
  localparam logic [6:0] LF = 7'h0A;
  localparam logic [6:0] BS = 7'h08;
  localparam logic [6:0] FF = 7'h0C;
  typedef enum logic [1:0] {CLEAR_ALL, IDLE, WRITE, CLEAR_ROW} state_t;
  function automatic logic [10:0] pack_addr(input logic [5:0] col, input logic [4:0] row);
    return {col, row};
  endfunction
  function automatic logic is_printable(input logic [6:0] c);
    return c >= 7'h20 && c <= 7'h7E;
  endfunction
endpackage

// File: rtl/char_cursor.sv
// char_cursor: column/row cursor with advance, carriage return, line feed, backspace and home
module char_cursor
  import char_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       adv,
  input  logic       cr,
  input  logic       lf,
  input  logic       bs,
  input  logic       home,
  output logic [5:0] col,
  output logic [4:0] row,
  output logic       wrap,
  output logic       back_ok,
  output logic [5:0] back_col,
  output logic [4:0] back_row
);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  logic [4:0] row_adv;
  // backspace target, next row and the bottom-row wrap flag
  always_comb begin
    back_ok = col != 6'd0 || row != 5'd0;
    back_col = col != 6'd0 ? col - 6'd1 : LAST_COL;
    back_row = col != 6'd0 ? row : row - 5'd1;
    row_adv = row == LAST_ROW ? 5'd0 : row + 5'd1;
    wrap = (lf || (adv && col == LAST_COL)) && row == LAST_ROW;
  end
  // cursor counters move only through the explicit operations
  always_ff @(posedge clock) begin
    if (!reset_n || home) begin
      col <= 6'd0;
      row <= 5'd0;
    end else if (adv) begin
      col <= col == LAST_COL ? 6'd0 : col + 6'd1;
      if (col == LAST_COL) row <= row_adv;
    end else if (cr) begin
      col <= 6'd0;
    end else if (lf) begin
      row <= row_adv;
    end else if (bs && back_ok) begin
      col <= back_col;
      row <= back_row;
    end
  end
endmodule

// File: rtl/char_writer.sv
// char_writer: writes a handshaked ASCII stream into character RAM at a tracked cursor
module char_writer
  import char_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [10:0] ram_write_addr,
  output logic [6:0]  ram_write_data,
  output logic        ram_we,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);
  state_t state, nxt_state;
  logic [10:0] cnt, nxt_cnt, nxt_addr;
  logic [6:0] code, nxt_code, nxt_data;
  logic nxt_we, nxt_ready, nxt_busy;
  logic adv, cr, lf, bs, home, wrap, back_ok;
  logic [5:0] back_col;
  logic [4:0] back_row;
  char_cursor u_cursor (
    .clock(clock),
    .reset_n(reset_n),
    .adv(adv),
    .cr(cr),
    .lf(lf),
    .bs(bs),
    .home(home),
    .col(cursor_col),
    .row(cursor_row),
    .wrap(wrap),
    .back_ok(back_ok),
    .back_col(back_col),
    .back_row(back_row)
  );
  // next state and next registered outputs; the code is acted on the cycle after its handshake
  always_comb begin
    nxt_state = state;
    nxt_cnt = cnt;
    nxt_code = code;
    nxt_we = 1'b0;
    nxt_addr = ram_write_addr;
    nxt_data = ram_write_data;
    nxt_ready = 1'b0;
    nxt_busy = 1'b0;
    adv = 1'b0;
    cr = 1'b0;
    lf = 1'b0;
    bs = 1'b0;
    home = 1'b0;
    case (state)
      CLEAR_ALL: begin
        if (ram_we && cnt == 11'd0) begin
          nxt_state = IDLE;
          nxt_ready = 1'b1;
          home = 1'b1;
        end else begin
          nxt_we = 1'b1;
          nxt_addr = cnt;
          nxt_data = BLANK;
          nxt_cnt = cnt + 11'd1;
          nxt_busy = 1'b1;
        end
      end
      IDLE: begin
        nxt_ready = 1'b1;
        if (char_valid && char_ready) begin
          nxt_ready = 1'b0;
          nxt_code = char_in;
          nxt_state = WRITE;
          if (is_printable(char_in)) begin
            nxt_we = 1'b1;
            nxt_addr = pack_addr(cursor_col, cursor_row);
            nxt_data = char_in;
          end else if (char_in == BS && back_ok) begin
            nxt_we = 1'b1;
            nxt_addr = pack_addr(back_col, back_row);
            nxt_data = BLANK;
          end
        end
      end
      WRITE: begin
        adv = is_printable(code);
        cr = code == CR;
        lf = code == LF;
        bs = code == BS;
        if (code == FF) begin
          nxt_state = CLEAR_ALL;
          nxt_cnt = 11'd0;
          nxt_busy = 1'b1;
          home = 1'b1;
        end else if (wrap) begin
          nxt_state = CLEAR_ROW;
          nxt_cnt = 11'd0;
          nxt_busy = 1'b1;
        end else begin
          nxt_state = IDLE;
          nxt_ready = 1'b1;
        end
      end
      default: begin
        if (cnt == 11'(COLS)) begin
          nxt_state = IDLE;
          nxt_ready = 1'b1;
        end else begin
          nxt_we = 1'b1;
          nxt_addr = pack_addr(cnt[5:0], cursor_row);
          nxt_data = BLANK;
          nxt_cnt = cnt + 11'd1;
          nxt_busy = 1'b1;
        end
      end
    endcase
  end
  // state and output registers; reset restarts the full-screen clear
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= CLEAR_ALL;
      cnt <= 11'd0;
      code <= 7'd0;
      ram_we <= 1'b0;
      ram_write_addr <= 11'd0;
      ram_write_data <= 7'd0;
      char_ready <= 1'b0;
      busy <= 1'b1;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      code <= nxt_code;
      ram_we <= nxt_we;
      ram_write_addr <= nxt_addr;
      ram_write_data <= nxt_data;
      char_ready <= nxt_ready;
      busy <= nxt_busy;
    end
  end
endmodule

// File: tb/tb_char_writer.sv
// tb_char_writer: random code stream checked against a behavioural screen-writer model
module tb_char_writer;
  localparam int NC = 64;
  localparam int NR = 30;
  logic clock, reset_n, char_valid, char_ready, ram_we, busy;
  logic [6:0] char_in, ram_write_data;
  logic [10:0] ram_write_addr;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;
  int total = 0, bad = 0, wcount = 0, last_addr = 0, last_data = 0;
  int m_col = 0, m_row = 0, w0, n;
  int exp_q[$];
  char_writer dut (
    .clock(clock),
    .reset_n(reset_n),
    .char_in(char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data),
    .ram_we(ram_we),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy(busy)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input int addr, input int data);
    exp_q.push_back(addr * 128 + data);
  endtask
  task automatic push_clear_all();
    for (int i = 0; i < 2048; i++) push(i, 32);
  endtask
  task automatic row_adv();
    if (m_row < NR - 1) m_row++;
    else begin
      m_row = 0;
      for (int i = 0; i < NC; i++) push(i * 32, 32);
    end
  endtask
  task automatic model(input int c);
    if (c >= 32 && c <= 126) begin
      push(m_col * 32 + m_row, c);
      if (m_col == NC - 1) begin
        m_col = 0;
        row_adv();
      end else m_col++;
    end else if (c == 13) m_col = 0;
    else if (c == 10) row_adv();
    else if (c == 8) begin
      if (m_col > 0) begin
        m_col--;
        push(m_col * 32 + m_row, 32);
      end else if (m_row > 0) begin
        m_col = NC - 1;
        m_row--;
        push(m_col * 32 + m_row, 32);
      end
    end else if (c == 12) begin
      push_clear_all();
      m_col = 0;
      m_row = 0;
    end
  endtask
  task automatic send(input logic [6:0] c);
    int k = 0;
    char_in = c;
    char_valid = 1'b1;
    do begin
      @(negedge clock);
      #1;
      k++;
    end while (!char_ready && k < 5000);
    total++;
    if (!char_ready) begin
      bad++;
      $display("FAIL send_timeout actual=0 required=1 code=%0h", c);
    end else model(c);
    @(posedge clock);
    #1;
    char_valid = 1'b0;
  endtask
  task automatic wait_ready();
    int k = 0;
    while (!char_ready && k < 5000) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("ready_timeout", char_ready, 1);
  endtask
  task automatic goto_row(input int r);
    send(7'h0D);
    while (m_row != r) send(7'h0A);
  endtask
  // every RAM write must be the next one the model expects; idle cursor must match the model
  always @(negedge clock) begin
    if (reset_n) begin
      if (ram_we) begin
        wcount++;
        last_addr = ram_write_addr;
        last_data = ram_write_data;
        check("ready_low_on_write", char_ready, 0);
        if (exp_q.size() == 0) check("unexpected_write", ram_write_addr, -1);
        else check("write", {ram_write_addr, ram_write_data}, exp_q.pop_front());
      end
      if (char_ready) begin
        check("cursor_col", cursor_col, m_col);
        check("cursor_row", cursor_row, m_row);
        check("busy_idle", busy, 0);
      end
    end
  end
  initial begin
    reset_n = 1'b0;
    char_valid = 1'b0;
    char_in = 7'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_write_addr, 0);
    check("rst_data", ram_write_data, 0);
    check("rst_ready", char_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_col", cursor_col, 0);
    check("rst_row", cursor_row, 0);
    char_valid = 1'b1;
    char_in = 7'h51;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    push_clear_all();
    n = 0;
    while (wcount < 1000 && n < 5000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("partial_clear_count", wcount, 1000);
    check("ready_during_clear", char_ready, 0);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    push_clear_all();
    w0 = wcount;
    wait_ready();
    check("clear_all_len", wcount - w0, 2048);
    check("init_col", cursor_col, 0);
    send(7'h51);
    @(negedge clock);
    #1;
    check("held_q_addr", last_addr, 0);
    check("held_q_data", last_data, 7'h51);
    send(7'h0C);
    send(7'h41);
    @(negedge clock);
    #1;
    check("a_addr", last_addr, 0);
    check("a_data", last_data, 7'h41);
    send(7'h42);
    @(negedge clock);
    #1;
    check("b_addr", last_addr, 32);
    check("b_data", last_data, 7'h42);
    wait_ready();
    check("ab_col", cursor_col, 2);
    check("ab_row", cursor_row, 0);
    goto_row(5);
    repeat (63) send(7'($urandom_range(32, 126)));
    send(7'h5A);
    @(negedge clock);
    #1;
    check("z_addr", last_addr, 2021);
    check("z_data", last_data, 7'h5A);
    wait_ready();
    check("z_col", cursor_col, 0);
    check("z_row", cursor_row, 6);
    goto_row(29);
    send(7'h0A);
    w0 = wcount;
    @(posedge clock);
    #1;
    repeat (64) begin
      @(negedge clock);
      #1;
      check("busy_clear_row", busy, 1);
    end
    wait_ready();
    check("clear_row_len", wcount - w0, 64);
    check("lf_wrap_row", cursor_row, 0);
    goto_row(3);
    send(7'h08);
    @(negedge clock);
    #1;
    check("bs_addr", last_addr, 2018);
    check("bs_data", last_data, 7'h20);
    wait_ready();
    check("bs_col", cursor_col, 63);
    check("bs_row", cursor_row, 2);
    goto_row(0);
    wait_ready();
    w0 = wcount;
    send(7'h08);
    wait_ready();
    repeat (3) @(posedge clock);
    #1;
    check("bs_home_writes", wcount - w0, 0);
    check("bs_home_col", cursor_col, 0);
    for (int i = 0; i < 400; i++) begin
      int r, c;
      r = $urandom_range(0, 199);
      if (r < 140) c = $urandom_range(32, 126);
      else if (r < 155) c = 13;
      else if (r < 175) c = 10;
      else if (r < 191) c = 8;
      else if (r < 198) begin
        c = $urandom_range(0, 31);
        if (c == 13 || c == 10 || c == 8 || c == 12) c = 127;
      end else c = 12;
      send(7'(c));
    end
    wait_ready();
    repeat (5) @(posedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
